// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: prefetching fetch stage with in-order response FIFO and flush-aware response accounting
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET_VALUE = 32'h0000_0000,
    parameter int          FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
    logic [CW-1:0] count_q, count_d, live_q, live_d, discard_q, discard_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [31:0]   instr_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem [FIFO_DEPTH];
    logic [CW:0]   occupancy;
    logic          hs, rsp_live, push, pop;

    assign target          = {redirect_pc[31:2], 2'b00};
    // Buffered entries plus responses still owed to them bound new requests, so the FIFO never overflows.
    assign occupancy       = {1'b0, count_q} + {1'b0, live_q};
    assign imem_req_valid  = !rst && !redirect_valid && (occupancy < DEPTH);
    assign imem_req_addr   = fetch_pc_q;
    assign out_valid       = !rst && !redirect_valid && (count_q != '0);
    assign out_instruction = instr_mem[rd_q];
    assign out_pc          = pc_mem[rd_q];
    assign hs              = imem_req_valid && imem_req_ready;
    assign rsp_live        = imem_rsp_valid && (discard_q == '0);
    assign push            = rsp_live && !redirect_valid;
    assign pop             = out_valid && out_ready;

    always_comb begin
        fetch_pc_d = redirect_valid ? target : (hs ? fetch_pc_q + 32'd4 : fetch_pc_q);
        rsp_pc_d   = redirect_valid ? target : (push ? rsp_pc_q + 32'd4 : rsp_pc_q);
        live_d     = redirect_valid ? '0 : live_q + CW'(hs) - CW'(rsp_live);
        discard_d  = redirect_valid ? discard_q + live_q - CW'(imem_rsp_valid)
                                    : discard_q - CW'(imem_rsp_valid && !rsp_live);
        count_d    = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        wr_d       = redirect_valid ? '0 : wr_q + PW'(push);
        rd_d       = redirect_valid ? '0 : rd_q + PW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= PC_RESET_VALUE;
            rsp_pc_q   <= PC_RESET_VALUE;
            live_q     <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            live_q     <= live_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            instr_mem[wr_q] <= imem_rsp_data;
            pc_mem[wr_q]    <= rsp_pc_q;
        end
    end
endmodule
